// File: rtl/regf_arb_pkg.sv
// -----------------------------------------------------------------------------
// regf_arb_pkg
// Shared types for the register-file write-port arbiter slice.
//   arb_state_e : arbiter FSM states (ARB normal arbitration, FORCE starvation
//                 drain; the FSM only exists when REGF_ARB_STARVE_GUARD_EN is
//                 defined)
//   reg_addr_t  : register address (REGF_ADDR_W bits)
//   reg_data_t  : register data (REGF_DATA_W bits)
//   lu_wreq_t   : long-latency unit write request {addr, data}
// -----------------------------------------------------------------------------
package regf_arb_pkg;

  localparam int unsigned REGF_ADDR_W = 5;
  localparam int unsigned REGF_DATA_W = 32;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    FORCE = 1'b1
  } arb_state_e;

  typedef logic [REGF_ADDR_W-1:0] reg_addr_t;
  typedef logic [REGF_DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } lu_wreq_t;

  // x0 is hardwired: writes to it are dropped and it is never tracked busy.
  function automatic logic is_x0(input reg_addr_t a);
    return (a == '0);
  endfunction

endpackage

// File: rtl/regf_scoreboard.sv
// -----------------------------------------------------------------------------
// regf_scoreboard
// Busy-bit vector for registers whose value is still owed by the long-latency
// unit (issued but not yet written back through the holding buffer).
// Ports:
//   clk_i, rstn_i          clock, async active-low reset (clears all bits)
//   set_i, set_addr_i      mark a destination busy (LU issue)
//   clr_i, clr_addr_i      release a destination (holding-buffer drain)
//   rs1/rs2/rd_addr_i      three lookup addresses from ID
//   rs1/rs2/rd_busy_o      lookup results, with drain bypass
// -----------------------------------------------------------------------------
module regf_scoreboard
  import regf_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REGF_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  set_i,
  input  logic [ADDR_WIDTH-1:0] set_addr_i,
  input  logic                  clr_i,
  input  logic [ADDR_WIDTH-1:0] clr_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,
  output logic                  rd_busy_o
);

  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] r_busy;

  // Clear is applied first so that a same-cycle issue to the register being
  // drained leaves it busy (the new producer owns it).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_busy <= '0;
    end else begin
      if (clr_i && (clr_addr_i != '0)) begin
        r_busy[clr_addr_i] <= 1'b0;
      end
      if (set_i && (set_addr_i != '0)) begin
        r_busy[set_addr_i] <= 1'b1;
      end
    end
  end

  // The register file forwards the write to a same-cycle read, so a register
  // being drained this cycle already reads correctly and is reported free.
  function automatic logic busy_lookup(input logic [NREG-1:0]       busy,
                                       input logic [ADDR_WIDTH-1:0] a,
                                       input logic                  clr,
                                       input logic [ADDR_WIDTH-1:0] clr_a);
    return busy[a] && !(clr && (clr_a == a)) && (a != '0);
  endfunction

  assign rs1_busy_o = busy_lookup(r_busy, rs1_addr_i, clr_i, clr_addr_i);
  assign rs2_busy_o = busy_lookup(r_busy, rs2_addr_i, clr_i, clr_addr_i);
  assign rd_busy_o  = busy_lookup(r_busy, rd_addr_i,  clr_i, clr_addr_i);

endmodule

// File: rtl/regf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// regf_wport_arbiter
// Shares the single register-file write port between the in-order WB stage
// (priority, no backpressure) and a long-latency unit (LU). LU results are
// parked in a 1-entry holding buffer and written in cycles WB leaves free.
// A busy-bit scoreboard tracks LU destinations in flight for ID hazard stalls.
//
// Optional feature (macro REGF_ARB_STARVE_GUARD_EN): after STARVE_LIMIT
// consecutive cycles of WB blocking a full buffer, one FORCE cycle freezes WB
// (pipe_stall_o=1) and drains the buffer. Undefined: pipe_stall_o is 0 and
// the buffer waits for a WB-free cycle indefinitely.
//
// Ports:
//   clk_i, rstn_i                      clock, async active-low reset
//   lu_issue_i, lu_issue_rd_i          LU op issued, destination (sets busy)
//   wb_write_i, wb_waddr_i, wb_wdata_i WB write request
//   lu_valid_i, lu_waddr_i, lu_wdata_i LU result; lu_ready_o = buffer empty
//   rs1/rs2/rd_addr_i                  ID lookups; rs1/rs2/rd_busy_o results
//   rf_write_o, rf_waddr_o, rf_wdata_o register file write port
//   pipe_stall_o                       freeze WB (FORCE cycle only)
// -----------------------------------------------------------------------------
module regf_wport_arbiter
  import regf_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = REGF_ADDR_W,
  parameter int unsigned REG_SIZE     = REGF_DATA_W,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  lu_issue_i,
  input  logic [ADDR_WIDTH-1:0] lu_issue_rd_i,
  input  logic                  wb_write_i,
  input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
  input  logic [REG_SIZE-1:0]   wb_wdata_i,
  input  logic                  lu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lu_waddr_i,
  input  logic [REG_SIZE-1:0]   lu_wdata_i,
  output logic                  lu_ready_o,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,
  output logic                  rd_busy_o,
  output logic                  rf_write_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [REG_SIZE-1:0]   rf_wdata_o,
  output logic                  pipe_stall_o
);

  // The holding buffer uses the package struct, so widths must match it.
  if ((ADDR_WIDTH != REGF_ADDR_W) || (REG_SIZE != REGF_DATA_W)) begin : g_width_err
    $error("regf_wport_arbiter: ADDR_WIDTH/REG_SIZE must match regf_arb_pkg");
  end
  if (STARVE_LIMIT < 1) begin : g_limit_err
    $error("regf_wport_arbiter: STARVE_LIMIT must be at least 1");
  end

  logic     r_buf_valid;
  lu_wreq_t r_buf;
  logic     w_accept;
  logic     w_force;
  logic     w_wb_grant;
  logic     w_drain;

  // ---------------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------------
`ifdef REGF_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_conflict;

  assign w_force    = (r_state == FORCE);
  // A conflict is a cycle where WB wins while the buffer is waiting.
  assign w_conflict = r_buf_valid && wb_write_i && !w_force;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ARB;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        FORCE: begin
          r_state      <= ARB;
          r_starve_cnt <= '0;
        end
        default: begin
          if (w_conflict) begin
            if (r_starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
              r_state      <= FORCE;
              r_starve_cnt <= '0;
            end else begin
              r_starve_cnt <= r_starve_cnt + 1'b1;
            end
          end else begin
            r_starve_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign pipe_stall_o = w_force;
`else
  assign w_force      = 1'b0;
  assign pipe_stall_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Grant and holding buffer
  // ---------------------------------------------------------------------------
  // WB has priority unless a FORCE cycle is freezing it (WB then retries).
  assign w_wb_grant = wb_write_i && !w_force;
  assign w_drain    = r_buf_valid && !w_wb_grant;

  // Ready is purely registered: a slot freed by a drain is reusable only from
  // the following cycle, so accept and drain never coincide.
  assign lu_ready_o = !r_buf_valid;
  assign w_accept   = lu_valid_i && lu_ready_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_buf_valid <= 1'b0;
    end else if (w_accept) begin
      r_buf_valid <= 1'b1;
    end else if (w_drain) begin
      r_buf_valid <= 1'b0;
    end
  end

  // Payload is qualified by r_buf_valid, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_buf.addr <= reg_addr_t'(lu_waddr_i);
      r_buf.data <= reg_data_t'(lu_wdata_i);
    end
  end

  always_comb begin
    rf_write_o = 1'b0;
    rf_waddr_o = wb_waddr_i;
    rf_wdata_o = wb_wdata_i;
    if (w_wb_grant) begin
      rf_write_o = !is_x0(reg_addr_t'(wb_waddr_i));
    end else if (w_drain) begin
      // An x0 result still drains the buffer; only the write is suppressed.
      rf_write_o = !is_x0(r_buf.addr);
      rf_waddr_o = ADDR_WIDTH'(r_buf.addr);
      rf_wdata_o = REG_SIZE'(r_buf.data);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  regf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .set_i      (lu_issue_i),
    .set_addr_i (lu_issue_rd_i),
    .clr_i      (w_drain),
    .clr_addr_i (ADDR_WIDTH'(r_buf.addr)),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rd_addr_i  (rd_addr_i),
    .rs1_busy_o (rs1_busy_o),
    .rs2_busy_o (rs2_busy_o),
    .rd_busy_o  (rd_busy_o)
  );

endmodule

// File: tb/tb_regf_wport_arbiter.sv
module tb_regf_wport_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SL = 8;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          lu_issue_i;
  logic [AW-1:0] lu_issue_rd_i;
  logic          wb_write_i;
  logic [AW-1:0] wb_waddr_i;
  logic [DW-1:0] wb_wdata_i;
  logic          lu_valid_i;
  logic [AW-1:0] lu_waddr_i;
  logic [DW-1:0] lu_wdata_i;
  logic          lu_ready_o;
  logic [AW-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic          rs1_busy_o, rs2_busy_o, rd_busy_o;
  logic          rf_write_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          pipe_stall_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  regf_wport_arbiter #(.ADDR_WIDTH(AW), .REG_SIZE(DW), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .lu_issue_i(lu_issue_i), .lu_issue_rd_i(lu_issue_rd_i),
    .wb_write_i(wb_write_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .lu_valid_i(lu_valid_i), .lu_waddr_i(lu_waddr_i), .lu_wdata_i(lu_wdata_i),
    .lu_ready_o(lu_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o), .rd_busy_o(rd_busy_o),
    .rf_write_o(rf_write_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .pipe_stall_o(pipe_stall_o)
  );

  task automatic idle_inputs();
    lu_issue_i = 0; lu_issue_rd_i = '0;
    wb_write_i = 0; wb_waddr_i = '0; wb_wdata_i = '0;
    lu_valid_i = 0; lu_waddr_i = '0; lu_wdata_i = '0;
    rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rs1_addr_i = 5'd7; rs2_addr_i = 5'd4; rd_addr_i = 5'd9;
    #1;
    total_cnt++; if (lu_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", lu_ready_o); else pass_cnt++;
    total_cnt++; if (pipe_stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", pipe_stall_o); else pass_cnt++;
    total_cnt++; if (rf_write_o !== 1'b0) $display("FAIL reset_rfwrite: got %b want 0", rf_write_o); else pass_cnt++;
    total_cnt++; if ({rs1_busy_o, rs2_busy_o, rd_busy_o} !== 3'b000) $display("FAIL reset_busy: got %b want 000", {rs1_busy_o, rs2_busy_o, rd_busy_o}); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_accept_drain();
    idle_inputs();
    lu_valid_i = 1; lu_waddr_i = 5'd5; lu_wdata_i = 32'hDEAD;
    #1;
    total_cnt++; if (lu_ready_o !== 1'b1) $display("FAIL acc_ready_pre: got %b want 1", lu_ready_o); else pass_cnt++;
    total_cnt++; if (rf_write_o !== 1'b0) $display("FAIL acc_nowrite_same_cycle: got %b want 0", rf_write_o); else pass_cnt++;
    next_cycle();
    lu_valid_i = 0;
    #1;
    total_cnt++; if (lu_ready_o !== 1'b0) $display("FAIL acc_ready_full: got %b want 0", lu_ready_o); else pass_cnt++;
    total_cnt++; if (rf_write_o !== 1'b1) $display("FAIL acc_drain_write: got %b want 1", rf_write_o); else pass_cnt++;
    total_cnt++; if (rf_waddr_o !== 5'd5) $display("FAIL acc_drain_addr: got %0d want 5", rf_waddr_o); else pass_cnt++;
    total_cnt++; if (rf_wdata_o !== 32'hDEAD) $display("FAIL acc_drain_data: got %h want dead", rf_wdata_o); else pass_cnt++;
    next_cycle();
    total_cnt++; if (lu_ready_o !== 1'b1) $display("FAIL acc_ready_after: got %b want 1", lu_ready_o); else pass_cnt++;
    total_cnt++; if (rf_write_o !== 1'b0) $display("FAIL acc_idle_after: got %b want 0", rf_write_o); else pass_cnt++;
  endtask

  task automatic test_raw_busy();
    idle_inputs();
    lu_issue_i = 1; lu_issue_rd_i = 5'd7; rs1_addr_i = 5'd7; rd_addr_i = 5'd7;
    #1;
    total_cnt++; if (rs1_busy_o !== 1'b0) $display("FAIL raw_before_set: got %b want 0", rs1_busy_o); else pass_cnt++;
    next_cycle();
    lu_issue_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (rs1_busy_o !== 1'b1) $display("FAIL raw_rs1_busy[%0d]: got %b want 1", i, rs1_busy_o); else pass_cnt++;
      total_cnt++; if (rd_busy_o !== 1'b1) $display("FAIL raw_rd_busy[%0d]: got %b want 1", i, rd_busy_o); else pass_cnt++;
      next_cycle();
    end
    lu_valid_i = 1; lu_waddr_i = 5'd7; lu_wdata_i = 32'h1234;
    next_cycle();
    lu_valid_i = 0;
    #1;
    total_cnt++; if (rf_write_o !== 1'b1 || rf_waddr_o !== 5'd7) $display("FAIL raw_drain: got we=%b addr=%0d want we=1 addr=7", rf_write_o, rf_waddr_o); else pass_cnt++;
    total_cnt++; if (rs1_busy_o !== 1'b0) $display("FAIL raw_drain_bypass: got %b want 0", rs1_busy_o); else pass_cnt++;
    next_cycle();
    total_cnt++; if (rs1_busy_o !== 1'b0) $display("FAIL raw_cleared: got %b want 0", rs1_busy_o); else pass_cnt++;
  endtask

  task automatic test_wb_starve();
    idle_inputs();
    lu_issue_i = 1; lu_issue_rd_i = 5'd3;
    next_cycle();
    lu_issue_i = 0;
    lu_valid_i = 1; lu_waddr_i = 5'd3; lu_wdata_i = 32'h33;
    wb_write_i = 1; wb_waddr_i = 5'd10; wb_wdata_i = 32'hAAAA;
    rs1_addr_i = 5'd3;
    next_cycle();
    lu_valid_i = 0;
`ifdef REGF_ARB_STARVE_GUARD_EN
    for (int i = 0; i < SL; i++) begin
      #1;
      total_cnt++; if (pipe_stall_o !== 1'b0 || rf_waddr_o !== 5'd10 || lu_ready_o !== 1'b0) $display("FAIL starve_wait[%0d]: got stall=%b addr=%0d rdy=%b want 0/10/0", i, pipe_stall_o, rf_waddr_o, lu_ready_o); else pass_cnt++;
      next_cycle();
    end
    #1;
    total_cnt++; if (pipe_stall_o !== 1'b1) $display("FAIL starve_force_stall: got %b want 1", pipe_stall_o); else pass_cnt++;
    total_cnt++; if (rf_write_o !== 1'b1 || rf_waddr_o !== 5'd3 || rf_wdata_o !== 32'h33) $display("FAIL starve_force_write: got we=%b addr=%0d data=%h want 1/3/33", rf_write_o, rf_waddr_o, rf_wdata_o); else pass_cnt++;
    total_cnt++; if (rs1_busy_o !== 1'b0) $display("FAIL starve_force_bypass: got %b want 0", rs1_busy_o); else pass_cnt++;
    next_cycle();
    total_cnt++; if (pipe_stall_o !== 1'b0 || rf_waddr_o !== 5'd10 || lu_ready_o !== 1'b1) $display("FAIL starve_after: got stall=%b addr=%0d rdy=%b want 0/10/1", pipe_stall_o, rf_waddr_o, lu_ready_o); else pass_cnt++;
    wb_write_i = 0;
    next_cycle();
`else
    for (int i = 0; i < 12; i++) begin
      #1;
      total_cnt++; if (pipe_stall_o !== 1'b0 || rf_waddr_o !== 5'd10 || lu_ready_o !== 1'b0) $display("FAIL starve_wait[%0d]: got stall=%b addr=%0d rdy=%b want 0/10/0", i, pipe_stall_o, rf_waddr_o, lu_ready_o); else pass_cnt++;
      next_cycle();
    end
    wb_write_i = 0;
    #1;
    total_cnt++; if (rf_write_o !== 1'b1 || rf_waddr_o !== 5'd3 || rf_wdata_o !== 32'h33) $display("FAIL starve_late_drain: got we=%b addr=%0d data=%h want 1/3/33", rf_write_o, rf_waddr_o, rf_wdata_o); else pass_cnt++;
    next_cycle();
    total_cnt++; if (lu_ready_o !== 1'b1) $display("FAIL starve_ready_after: got %b want 1", lu_ready_o); else pass_cnt++;
`endif
  endtask

  task automatic test_drain_issue_same();
    idle_inputs();
    lu_issue_i = 1; lu_issue_rd_i = 5'd9;
    next_cycle();
    lu_issue_i = 0;
    lu_valid_i = 1; lu_waddr_i = 5'd9; lu_wdata_i = 32'h99;
    next_cycle();
    lu_valid_i = 0;
    lu_issue_i = 1; lu_issue_rd_i = 5'd9; rd_addr_i = 5'd9; rs1_addr_i = 5'd9;
    #1;
    total_cnt++; if (rf_write_o !== 1'b1 || rf_waddr_o !== 5'd9) $display("FAIL same_drain: got we=%b addr=%0d want 1/9", rf_write_o, rf_waddr_o); else pass_cnt++;
    total_cnt++; if (rd_busy_o !== 1'b0) $display("FAIL same_rd_free: got %b want 0", rd_busy_o); else pass_cnt++;
    next_cycle();
    lu_issue_i = 0;
    #1;
    total_cnt++; if (rs1_busy_o !== 1'b1) $display("FAIL same_set_wins: got %b want 1", rs1_busy_o); else pass_cnt++;
    lu_valid_i = 1; lu_waddr_i = 5'd9; lu_wdata_i = 32'h98;
    next_cycle();
    lu_valid_i = 0;
    next_cycle();
    total_cnt++; if (rs1_busy_o !== 1'b0) $display("FAIL same_second_clear: got %b want 0", rs1_busy_o); else pass_cnt++;
  endtask

  task automatic test_addr_zero();
    idle_inputs();
    lu_valid_i = 1; lu_waddr_i = 5'd0; lu_wdata_i = 32'hFFFF;
    next_cycle();
    lu_valid_i = 0;
    #1;
    total_cnt++; if (rf_write_o !== 1'b0) $display("FAIL x0_dropped: got %b want 0", rf_write_o); else pass_cnt++;
    total_cnt++; if (lu_ready_o !== 1'b0) $display("FAIL x0_full: got %b want 0", lu_ready_o); else pass_cnt++;
    next_cycle();
    total_cnt++; if (lu_ready_o !== 1'b1) $display("FAIL x0_drained: got %b want 1", lu_ready_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    lu_issue_i = 1; lu_issue_rd_i = 5'd4;
    next_cycle();
    lu_issue_i = 0;
    lu_valid_i = 1; lu_waddr_i = 5'd4; lu_wdata_i = 32'h44;
    wb_write_i = 1; wb_waddr_i = 5'd12; wb_wdata_i = 32'hC;
    rs1_addr_i = 5'd4;
    next_cycle();
    lu_valid_i = 0;
    #1;
    total_cnt++; if (lu_ready_o !== 1'b0 || rs1_busy_o !== 1'b1) $display("FAIL rstmid_pre: got rdy=%b busy=%b want 0/1", lu_ready_o, rs1_busy_o); else pass_cnt++;
    #2 rstn_i = 1'b0;
    #1;
    total_cnt++; if (lu_ready_o !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", lu_ready_o); else pass_cnt++;
    total_cnt++; if (rs1_busy_o !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", rs1_busy_o); else pass_cnt++;
    total_cnt++; if (pipe_stall_o !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", pipe_stall_o); else pass_cnt++;
    idle_inputs();
    @(posedge clk_i);
    #1 rstn_i = 1'b1;
  endtask

  // Randomized traffic against a transaction-level model: a queue of owed LU
  // results, an optional buffered request, and a set of pending registers.
  task automatic test_random();
    bit            m_buf_valid;
    logic [AW-1:0] m_buf_addr;
    logic [DW-1:0] m_buf_data;
    bit            m_pending[32];
    bit            m_force;
    int            m_starve;
    logic [AW-1:0] owed_q[$];
    bit            lu_pres;
    logic [AW-1:0] lu_pa;
    logic [DW-1:0] lu_pd;
    bit            wb_wins, drain, exp_we;
    logic [AW-1:0] exp_addr, r, a;
    logic [DW-1:0] exp_data;
    bit            e1, e2, e3, conflict;

    do_reset();
    m_buf_valid = 0; m_force = 0; m_starve = 0; lu_pres = 0;
    m_buf_addr = '0; m_buf_data = '0; lu_pa = '0; lu_pd = '0;
    for (int k = 0; k < 32; k++) m_pending[k] = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!lu_pres && owed_q.size() > 0 && ($urandom % 2 == 0)) begin
        lu_pres = 1; lu_pa = owed_q.pop_front(); lu_pd = $urandom;
      end
      lu_valid_i = lu_pres; lu_waddr_i = lu_pa; lu_wdata_i = lu_pd;
      wb_write_i = ($urandom % 3) != 0;
      a = AW'($urandom % 32);
      if (m_pending[a]) a = '0;
      wb_waddr_i = a; wb_wdata_i = $urandom;
      lu_issue_i = 0; lu_issue_rd_i = AW'($urandom % 32);
      r = AW'(1 + $urandom % 31);
      if (($urandom % 4 == 0) && !m_pending[r] && owed_q.size() < 4) begin
        lu_issue_i = 1; lu_issue_rd_i = r;
      end
      rs1_addr_i = AW'($urandom % 32); rs2_addr_i = AW'($urandom % 32); rd_addr_i = AW'($urandom % 32);
      #1;
      wb_wins  = wb_write_i && !m_force;
      drain    = m_buf_valid && !wb_wins;
      exp_addr = wb_wins ? wb_waddr_i : m_buf_addr;
      exp_data = wb_wins ? wb_wdata_i : m_buf_data;
      exp_we   = (wb_wins || drain) && (exp_addr != 0);
      e1 = m_pending[rs1_addr_i] && !(drain && m_buf_addr == rs1_addr_i);
      e2 = m_pending[rs2_addr_i] && !(drain && m_buf_addr == rs2_addr_i);
      e3 = m_pending[rd_addr_i]  && !(drain && m_buf_addr == rd_addr_i);
      total_cnt++; if (lu_ready_o !== !m_buf_valid) $display("FAIL rnd_ready c%0d: got %b want %b", cyc, lu_ready_o, !m_buf_valid); else pass_cnt++;
      total_cnt++; if (pipe_stall_o !== m_force) $display("FAIL rnd_stall c%0d: got %b want %b", cyc, pipe_stall_o, m_force); else pass_cnt++;
      total_cnt++; if (rf_write_o !== exp_we) $display("FAIL rnd_we c%0d: got %b want %b", cyc, rf_write_o, exp_we); else pass_cnt++;
      if (exp_we) begin
        total_cnt++; if (rf_waddr_o !== exp_addr || rf_wdata_o !== exp_data) $display("FAIL rnd_wport c%0d: got %0d/%h want %0d/%h", cyc, rf_waddr_o, rf_wdata_o, exp_addr, exp_data); else pass_cnt++;
      end
      total_cnt++; if ({rs1_busy_o, rs2_busy_o, rd_busy_o} !== {e1, e2, e3}) $display("FAIL rnd_busy c%0d: got %b want %b", cyc, {rs1_busy_o, rs2_busy_o, rd_busy_o}, {e1, e2, e3}); else pass_cnt++;
      @(posedge clk_i);
      conflict = m_buf_valid && wb_write_i && !m_force;
`ifdef REGF_ARB_STARVE_GUARD_EN
      if (m_force) begin
        m_force = 0; m_starve = 0;
      end else if (conflict) begin
        if (m_starve == SL - 1) begin m_force = 1; m_starve = 0; end
        else m_starve++;
      end else m_starve = 0;
`else
      if (conflict) m_starve++;
`endif
      if (drain) begin
        m_pending[m_buf_addr] = 0; m_buf_valid = 0;
      end else if (lu_pres && !m_buf_valid) begin
        m_buf_valid = 1; m_buf_addr = lu_pa; m_buf_data = lu_pd; lu_pres = 0;
      end
      if (lu_issue_i) begin
        m_pending[lu_issue_rd_i] = 1; owed_q.push_back(lu_issue_rd_i);
      end
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rstn_i = 1'b0;
    idle_inputs();
    test_reset();
    test_accept_drain();
    test_raw_busy();
    test_wb_starve();
    test_drain_issue_same();
    test_addr_zero();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
